// File: rtl/traffic_sensor_cond.sv
// Input conditioning ahead of the traffic-light controller: synchronizes and debounces
// two vehicle sensors and two mode buttons, stretches traffic flags and counts arrivals.
module traffic_sensor_cond #(
    parameter int DEB_CYC  = 4,
    parameter int HOLD_CYC = 8,
    parameter int CW       = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sens_a,
    input  logic       i_sens_b,
    input  logic       i_btn_p,
    input  logic       i_btn_r,
    input  logic       i_cnt_clr,
    output logic       o_traff_a,
    output logic       o_traff_b,
    output logic       o_mode_p,
    output logic       o_mode_r,
    output logic [7:0] o_cnt_a,
    output logic [7:0] o_cnt_b
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    // Channel order everywhere: 0 = road A, 1 = road B, 2 = button P, 3 = button R.
    logic [3:0]    raw;
    logic [3:0]    s1_q, s2_q;
    logic [3:0]    db_q, db_d;
    logic [CW-1:0] dcnt_q [4];
    logic [CW-1:0] dcnt_d [4];

    assign raw = {i_btn_r, i_btn_p, i_sens_b, i_sens_a};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]   = db_q[i];
            dcnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == CW'(DEB_CYC - 1)) db_d[i] = s2_q[i];
                else                               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1_q <= '0;
            s2_q <= '0;
            db_q <= '0;
            for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            db_q <= db_d;
            for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
        end
    end

    state_t        state_q [2];
    state_t        state_d [2];
    logic [CW-1:0] hcnt_q  [2];
    logic [CW-1:0] hcnt_d  [2];
    logic [1:0]    arrive;
    logic [1:0]    traff;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                hcnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            hcnt_d[i]  = hcnt_q[i];
            unique case (state_q[i])
                IDLE: if (db_q[i]) state_d[i] = BUSY;
                BUSY: if (!db_q[i]) begin
                    state_d[i] = HOLD;
                    hcnt_d[i]  = '0;
                end
                HOLD: begin
                    if (db_q[i])                              state_d[i] = BUSY;
                    else if (hcnt_q[i] == CW'(HOLD_CYC - 1)) state_d[i] = IDLE;
                    else                                      hcnt_d[i]  = hcnt_q[i] + 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Only a fresh IDLE->BUSY entry is a new vehicle; HOLD->BUSY is the same one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            traff[i]  = (state_q[i] != IDLE);
            arrive[i] = (state_q[i] == IDLE) && db_q[i];
        end
    end

    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i_cnt_clr)                           cnt_d[i] = '0;
            else if (arrive[i] && cnt_q[i] != 8'hFF) cnt_d[i] = cnt_q[i] + 8'd1;
        end
    end

    logic [1:0] db_dly_q;
    logic [1:0] rise;
    logic       mode_p_q, mode_r_q;

    assign rise = db_q[3:2] & ~db_dly_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            db_dly_q <= '0;
            mode_p_q <= 1'b0;
            mode_r_q <= 1'b0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            db_dly_q <= db_q[3:2];
            // Simultaneous P and R presses cancel each other.
            mode_p_q <= rise[0] & ~rise[1];
            mode_r_q <= rise[1] & ~rise[0];
        end
    end

    assign o_traff_a = traff[0];
    assign o_traff_b = traff[1];
    assign o_mode_p  = mode_p_q;
    assign o_mode_r  = mode_r_q;
    assign o_cnt_a   = cnt_q[0];
    assign o_cnt_b   = cnt_q[1];

endmodule
